// File: rtl/tt_pkg.sv
// Shared types and elaboration helpers for the truth-table scanner.
package tt_pkg;

   typedef enum logic [1:0] {IDLE, SETTLE, CAPTURE, DONE} tt_state_t;

   localparam int MAX_N    = 6;
   localparam int MAX_HOLD = 255;
   localparam int HOLD_W   = 8;

   // Truth-table width for an n-input function.
   function automatic int tt_width(input int n);
      return 1 << n;
   endfunction

   // True when the input count and settle time fit the hardware.
   function automatic bit tt_params_ok(input int n, input int hold);
      return (n >= 1) && (n <= MAX_N) && (hold >= 1) && (hold <= MAX_HOLD);
   endfunction

endpackage

// File: rtl/tt_hold_timer.sv
// 8-bit settle-delay down-counter: load a start value, count down while enabled,
// and report expiry when the count reaches zero.
module tt_hold_timer
   import tt_pkg::*;
(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              load,
   input  logic [HOLD_W-1:0] load_val,
   input  logic              en,
   output logic              expire
);

   logic [HOLD_W-1:0] cnt;

   // Load takes priority over counting; the count parks at zero.
   always_ff @(posedge clk) begin
      if (!rst_n)
         cnt <= '0;
      else if (load)
         cnt <= load_val;
      else if (en && (cnt != '0))
         cnt <= cnt - 8'd1;
   end

   assign expire = (cnt == '0);

endmodule

// File: rtl/truth_table_scanner.sv
// Exhaustive truth-table sweeper: drives every input row onto an external
// function, waits HOLD cycles, samples its output and compares the assembled
// table against an expected vector latched at start.
module truth_table_scanner
   import tt_pkg::*;
#(
   parameter  int N    = 3,
   parameter  int HOLD = 1,
   localparam int TT_W = tt_width(N)
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            start,
   input  logic            abort,
   input  logic [TT_W-1:0] expect_tt,   // expected table, bit i = output for row i
   input  logic            s_in,
   output logic [N-1:0]    vec_out,
   output logic            busy,
   output logic            done,
   output logic [TT_W-1:0] result,
   output logic [N:0]      ones_count,
   output logic            mismatch,
   output logic [N-1:0]    first_err
);

   if (!tt_params_ok(N, HOLD)) begin : g_bad_params
      $error("truth_table_scanner: N must be 1..6 and HOLD 1..255");
   end

   localparam logic [N-1:0] LAST_ROW = '1;

   tt_state_t       state, state_nxt;
   logic [TT_W-1:0] exp_q;
   logic            tmr_load, tmr_en, tmr_expire, cap;
   logic            last_row;

   assign last_row = (vec_out == LAST_ROW);
   assign busy     = (state == SETTLE) || (state == CAPTURE);
   assign done     = (state == DONE);

   tt_hold_timer u_hold (
      .clk      (clk),
      .rst_n    (rst_n),
      .load     (tmr_load),
      .load_val (8'(HOLD - 1)),
      .en       (tmr_en),
      .expire   (tmr_expire)
   );

   // State register.
   always_ff @(posedge clk) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   // Next-state logic; abort beats capture so an aborted row is never recorded.
   always_comb begin
      state_nxt = state;
      tmr_load  = 1'b0;
      tmr_en    = 1'b0;
      cap       = 1'b0;
      unique case (state)
         IDLE: begin
            if (start) begin
               state_nxt = SETTLE;
               tmr_load  = 1'b1;
            end
         end
         SETTLE: begin
            if (abort)           state_nxt = IDLE;
            else if (tmr_expire) state_nxt = CAPTURE;
            else                 tmr_en    = 1'b1;
         end
         CAPTURE: begin
            if (abort) begin
               state_nxt = IDLE;
            end else begin
               cap = 1'b1;
               if (last_row) begin
                  state_nxt = DONE;
               end else begin
                  state_nxt = SETTLE;
                  tmr_load  = 1'b1;
               end
            end
         end
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Datapath: row pointer, captured table, popcount and first-error tracking.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         exp_q      <= '0;
         vec_out    <= '0;
         result     <= '0;
         ones_count <= '0;
         mismatch   <= 1'b0;
         first_err  <= '0;
      end else if ((state == IDLE) && start) begin
         exp_q      <= expect_tt;
         vec_out    <= '0;
         result     <= '0;
         ones_count <= '0;
         mismatch   <= 1'b0;
         first_err  <= '0;
      end else if (busy && abort) begin
         vec_out <= '0;
      end else if (cap) begin
         result[vec_out] <= s_in;
         if (s_in) ones_count <= ones_count + (N+1)'(1);
         if ((s_in != exp_q[vec_out]) && !mismatch) begin
            first_err <= vec_out;
            mismatch  <= 1'b1;
         end
         if (!last_row) vec_out <= vec_out + N'(1);
      end
   end

endmodule

// File: tb/tb_truth_table_scanner.sv
// Directed bench: three scanner instances (N=3/HOLD=1, N=3/HOLD=3, N=1/HOLD=1)
// each wired to a small boolean function of its own vec_out.
module tb_truth_table_scanner;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;

   // Instance A: N=3, HOLD=1, f = ~(x|y)&~z
   logic       start_a = 0, abort_a = 0, s_a, busy_a, done_a, mis_a;
   logic [7:0] exp_a = '0, res_a;
   logic [2:0] vec_a, fe_a;
   logic [3:0] ones_a;
   assign s_a = ~(vec_a[2] | vec_a[1]) & ~vec_a[0];

   // Instance B: N=3, HOLD=3, f = x|y
   logic       start_b = 0, abort_b = 0, s_b, busy_b, done_b, mis_b;
   logic [7:0] exp_b = '0, res_b;
   logic [2:0] vec_b, fe_b;
   logic [3:0] ones_b;
   assign s_b = vec_b[2] | vec_b[1];

   // Instance C: N=1, HOLD=1, f = ~a
   logic       start_c = 0, abort_c = 0, s_c, busy_c, done_c, mis_c;
   logic [1:0] exp_c = '0, res_c, ones_c;
   logic [0:0] vec_c, fe_c;
   assign s_c = ~vec_c[0];

   truth_table_scanner #(.N(3), .HOLD(1)) dut_a (
      .clk(clk), .rst_n(rst_n), .start(start_a), .abort(abort_a), .expect_tt(exp_a),
      .s_in(s_a), .vec_out(vec_a), .busy(busy_a), .done(done_a), .result(res_a),
      .ones_count(ones_a), .mismatch(mis_a), .first_err(fe_a));

   truth_table_scanner #(.N(3), .HOLD(3)) dut_b (
      .clk(clk), .rst_n(rst_n), .start(start_b), .abort(abort_b), .expect_tt(exp_b),
      .s_in(s_b), .vec_out(vec_b), .busy(busy_b), .done(done_b), .result(res_b),
      .ones_count(ones_b), .mismatch(mis_b), .first_err(fe_b));

   truth_table_scanner #(.N(1), .HOLD(1)) dut_c (
      .clk(clk), .rst_n(rst_n), .start(start_c), .abort(abort_c), .expect_tt(exp_c),
      .s_in(s_c), .vec_out(vec_c), .busy(busy_c), .done(done_c), .result(res_c),
      .ones_count(ones_c), .mismatch(mis_c), .first_err(fe_c));

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] req);
      n_cmp++;
      assert (obs === req) else begin
         n_bad++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, req);
      end
   endtask

   // Advance one clock; inputs change and outputs are sampled 1 time unit later.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      bit seen;

      // Reset state
      rst_n = 1'b0;
      repeat (3) tick();
      check("rst_vec",  vec_a,  0);
      check("rst_busy", busy_a, 0);
      check("rst_done", done_a, 0);
      check("rst_res",  res_a,  0);
      check("rst_ones", ones_a, 0);
      check("rst_mis",  mis_a,  0);
      check("rst_fe",   fe_a,   0);
      rst_n = 1'b1;
      tick();

      // A: matching expectation, done 17 cycles after start
      exp_a = 8'h01; start_a = 1; abort_a = 1;   // start beats abort in IDLE
      tick();
      start_a = 0; abort_a = 0;
      check("a1_busy0", busy_a, 1);
      check("a1_vec0",  vec_a,  0);
      repeat (15) tick();
      check("a1_nodone15", done_a, 0);
      tick();
      check("a1_done", done_a, 1);
      check("a1_busy", busy_a, 0);
      check("a1_res",  res_a,  8'h01);
      check("a1_ones", ones_a, 1);
      check("a1_mis",  mis_a,  0);
      check("a1_fe",   fe_a,   0);
      check("a1_vec",  vec_a,  7);
      tick();
      check("a1_pulse", done_a, 0);
      check("a1_hold",  res_a,  8'h01);

      // A: mismatching expectation plus an ignored start mid-sweep
      exp_a = 8'h03; start_a = 1;
      tick();
      start_a = 0; exp_a = 8'h01;
      repeat (4) tick();
      start_a = 1;
      tick();
      start_a = 0;
      repeat (10) tick();
      check("a2_nodone15", done_a, 0);
      tick();
      check("a2_done", done_a, 1);
      check("a2_res",  res_a,  8'h01);
      check("a2_mis",  mis_a,  1);
      check("a2_fe",   fe_a,   1);
      tick();

      // B: HOLD=3, each row visible for 4 cycles, done 33 cycles after start
      exp_b = 8'hFC; start_b = 1;
      tick();
      start_b = 0;
      for (int t = 0; t < 32; t++) begin
         check($sformatf("b1_vec_t%0d", t), vec_b, t / 4);
         if (t == 31) check("b1_nodone32", done_b, 0);
         tick();
      end
      check("b1_done", done_b, 1);
      check("b1_res",  res_b,  8'hFC);
      check("b1_ones", ones_b, 6);
      check("b1_mis",  mis_b,  0);
      tick();

      // B: abort while row 4 is being presented
      start_b = 1;
      tick();
      start_b = 0;
      repeat (16) tick();
      check("b2_vec4", vec_b, 4);
      abort_b = 1;
      tick();
      abort_b = 0;
      check("b2_busy", busy_b, 0);
      check("b2_done", done_b, 0);
      check("b2_vec",  vec_b,  0);
      check("b2_hi",   res_b[7:4], 0);
      check("b2_res",  res_b,  8'h0C);
      check("b2_ones", ones_b, 2);
      seen = 0;
      repeat (40) begin tick(); if (done_b) seen = 1; end
      check("b2_nodone", seen, 0);

      // A: reset mid-sweep clears everything and no done follows
      exp_a = 8'h00; start_a = 1;
      tick();
      start_a = 0;
      repeat (5) tick();
      rst_n = 1'b0;
      tick();
      check("r_vec",  vec_a,  0);
      check("r_busy", busy_a, 0);
      check("r_res",  res_a,  0);
      check("r_ones", ones_a, 0);
      check("r_mis",  mis_a,  0);
      check("r_fe",   fe_a,   0);
      rst_n = 1'b1;
      seen = 0;
      repeat (20) begin tick(); if (done_a) seen = 1; end
      check("r_nodone", seen, 0);

      // C: N=1, done 5 cycles after start
      exp_c = 2'b01; start_c = 1;
      tick();
      start_c = 0;
      repeat (3) tick();
      check("c_nodone4", done_c, 0);
      tick();
      check("c_done", done_c, 1);
      check("c_res",  res_c,  2'b01);
      check("c_ones", ones_c, 1);
      check("c_mis",  mis_c,  0);
      check("c_fe",   fe_c,   0);
      tick();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/truth_table_scanner.md
# truth_table_scanner

Sequential truth-table capture engine for N-input combinational functions. The block drives every input combination 0..2^N-1 onto an external function under test and holds each one for a programmable settle time. It samples the function output and assembles the full truth table as a 2^N-bit vector, then compares it against an expected vector and reports count of ones, mismatch and first failing row. It replaces hand-written exhaustive stimulus sequences in the boolean-expression exercises with one reusable on-chip sweeper.

## Interface
- N, default 3: number of function inputs, legal 1..6.
- HOLD, default 1: clock cycles each combination is held before sampling, legal 1..255.
- TT_W, derived, 2^N: truth-table width.
- clk  input  1  rising-edge clock.
- rst_n  input  1  reset, synchronous, active-low.
- start  input  1  begin a sweep; honoured only in IDLE.
- abort  input  1  terminate a sweep; honoured only while busy.
- expect  input  TT_W  expected truth table; bit i is the output for row i; latched on accepted start.
- s_in  input  1  function-under-test output.
- vec_out  output  N  current input combination; vec_out[N-1] is the leftmost variable (x for N=3).
- busy  output  1  sweep in progress.
- done  output  1  one-cycle pulse after the last row is captured.
- result  output  TT_W  captured truth table.
- ones_count  output  N+1  number of 1 bits in result.
- mismatch  output  1  result != latched expect; valid from done onward.
- first_err  output  N  lowest row index where result and expect differ; 0 when mismatch=0.

## Operation
- States: IDLE, SETTLE, CAPTURE, DONE.
- IDLE: busy=0. When start=1, the block latches expect, clears result, ones_count, mismatch and first_err, sets vec_out=0, and goes to SETTLE.
- SETTLE: vec_out is held stable. A hold counter counts HOLD-1 further cycles, then the block goes to CAPTURE. With HOLD=1, the block passes straight through to CAPTURE.
- CAPTURE, one cycle per row:
  - result[vec_out] <= s_in.
  - ones_count increments when s_in=1.
  - If s_in != expect[vec_out] and no error has been recorded yet, first_err <= vec_out and mismatch <= 1.
  - If vec_out = TT_W-1, go to DONE. Otherwise vec_out increments and the block returns to SETTLE.
- DONE: done=1 for exactly one cycle, busy=0, then IDLE. result, ones_count, mismatch and first_err hold until the next accepted start or reset. vec_out holds TT_W-1.
- abort while busy: next state is IDLE, busy=0, no done pulse. result, ones_count, mismatch and first_err keep their partial values. vec_out is reset to 0.
- start while busy: ignored.
- Simultaneous start and abort in IDLE: start wins, because abort is meaningless there.
- Width rules:
  - vec_out never wraps past TT_W-1. The sweep ends there.
  - ones_count saturates naturally at TT_W, so N+1 bits suffice.
  - The hold counter is 8 bits.

## Timing
- Reset (rst_n=0 at a rising edge): state=IDLE and every output is 0 (vec_out, busy, done, result, ones_count, mismatch, first_err). rst_n low mid-sweep aborts with all outputs cleared, no done.
- Start accepted at edge E0. busy=1 and vec_out=0 are visible after E0.
- Each row occupies exactly HOLD+1 cycles: HOLD settle cycles plus 1 capture cycle. s_in is sampled at the end of the capture cycle.
- done is asserted in cycle TT_W*(HOLD+1)+1 after E0; busy drops in the same cycle.
- Earliest next start is the cycle after done.
- s_in must be settled within HOLD cycles of a vec_out change; the block adds no synchroniser.

## Structure
- Shared package tt_pkg holds:
  - state enum tt_state_t {IDLE, SETTLE, CAPTURE, DONE};
  - localparam helper for TT_W;
  - N/HOLD legality checks.
- One sub-module, tt_hold_timer: 8-bit down-counter with load/expire, instantiated once for the settle delay. All remaining logic stays in the top module.

## Test plan
- N=3, HOLD=1, s_in = ~(x|y)&~z from the three vec_out bits, expect=8'h01. Required: result=8'h01, ones_count=1, mismatch=0, first_err=0, done 17 cycles after start.
- Same function, expect=8'h03. Required: mismatch=1, first_err=1.
- N=3, HOLD=3, s_in = x|y. Required: result=8'hFC, ones_count=6, each vec_out value stable for 4 cycles, done 33 cycles after start.
- Abort asserted while vec_out=4. Required: busy=0 next cycle, no done, vec_out=0, result bits 7..4 still 0.
- start pulsed mid-sweep, and rst_n=0 mid-sweep. Required: the extra start changes nothing; reset clears all outputs next edge and no done occurs.
- N=1, HOLD=1, s_in = ~vec_out[0], expect=2'b01. Required: result=2'b01, ones_count=1, done 5 cycles after start.
